// File: rtl/layer7_fetch_pkg.sv
// Shared types and defaults for the layer-7 window fetcher.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
`include "def.svh"

package layer7_fetch_pkg;

  localparam int unsigned MAP_W_DEF  = 5;
  localparam int unsigned K_DEF      = 3;
  localparam int unsigned STRIDE_DEF = 1;
  localparam int unsigned DATA_W_DEF = `LAYER7_WEIGHT_INPUT_LENGTH;

  // Counter width; coordinates never exceed 7 because the map is at most 8x8.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // Row-major slot of tap (r,c) inside a KxK window.
  function automatic int unsigned tap_index(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned k = K_DEF);
    return r * k + c;
  endfunction

endpackage

// File: rtl/layer7_window_fetcher_if.sv
// Memory read port plus window handshake between fetcher, result memory and layer-7 engine.
// Latency: n/a (wires only); memory data is combinational from the address.
// Backpressure: win_ready low holds the presented window.
// Ports (master = fetcher): read_row_addr/read_col_addr/layer6_result_read_signal out,
// layer6_result_output in, win_valid/win_data/win_row/win_col out, win_ready in.
interface layer7_window_fetcher_if
  import layer7_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned K      = K_DEF
) ();

  logic [15:0]           read_row_addr;
  logic [15:0]           read_col_addr;
  logic                  layer6_result_read_signal;
  logic [DATA_W-1:0]     layer6_result_output;

  logic                  win_valid;
  logic                  win_ready;
  logic [K*K*DATA_W-1:0] win_data;
  logic [15:0]           win_row;
  logic [15:0]           win_col;

  modport master (
    output read_row_addr, read_col_addr, layer6_result_read_signal,
    input  layer6_result_output,
    output win_valid, win_data, win_row, win_col,
    input  win_ready
  );

  modport slave (
    input  read_row_addr, read_col_addr, layer6_result_read_signal,
    output layer6_result_output,
    input  win_valid, win_data, win_row, win_col,
    output win_ready
  );

endinterface

// File: rtl/def.svh
`ifndef LAYER7_DEF_SVH
`define LAYER7_DEF_SVH
// Width of one layer-6 result word (all channels packed).
`define LAYER7_WEIGHT_INPUT_LENGTH 16
`endif

// File: rtl/layer7_win_counter.sv
// Nested tap (tap_r,tap_c) and window-origin (wr,wc) counters for the window walk.
// Latency: counters update on the edge where the step/clear is sampled.
// Backpressure: counters hold whenever no step is requested.
// Ports: clk, rst, clear, tap_step, win_step in; tap_r, tap_c, wr, wc, tap_last, win_last out.
module layer7_win_counter
  import layer7_fetch_pkg::*;
#(
  parameter int unsigned MAP_W  = MAP_W_DEF,
  parameter int unsigned K      = K_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tap_step,
  input  logic             win_step,
  output logic [CNT_W-1:0] tap_r,
  output logic [CNT_W-1:0] tap_c,
  output logic [CNT_W-1:0] wr,
  output logic [CNT_W-1:0] wc,
  output logic             tap_last,
  output logic             win_last
);

  localparam logic [CNT_W-1:0] K_M1 = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAP_W - K);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(STRIDE);

  logic [CNT_W-1:0] tap_r_q, tap_r_d;
  logic [CNT_W-1:0] tap_c_q, tap_c_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] wc_q, wc_d;

  assign tap_last = (tap_r_q == K_M1) && (tap_c_q == K_M1);
  assign win_last = (wr_q == LAST) && (wc_q == LAST);

  // wr/wc hold pixel coordinates of the window origin, so they step by STRIDE.
  always_comb begin
    tap_r_d = tap_r_q;
    tap_c_d = tap_c_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    if (clear) begin
      tap_r_d = '0;
      tap_c_d = '0;
      wr_d    = '0;
      wc_d    = '0;
    end else begin
      if (tap_step) begin
        if (tap_last) begin
          tap_r_d = '0;
          tap_c_d = '0;
        end else if (tap_c_q == K_M1) begin
          tap_c_d = '0;
          tap_r_d = tap_r_q + 1'b1;
        end else begin
          tap_c_d = tap_c_q + 1'b1;
        end
      end
      if (win_step) begin
        tap_r_d = '0;
        tap_c_d = '0;
        if (wc_q < LAST) begin
          wc_d = wc_q + STEP;
        end else begin
          wc_d = '0;
          wr_d = wr_q + STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_r_q <= '0;
      tap_c_q <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
    end else begin
      tap_r_q <= tap_r_d;
      tap_c_q <= tap_c_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
    end
  end

  assign tap_r = tap_r_q;
  assign tap_c = tap_c_q;
  assign wr    = wr_q;
  assign wc    = wc_q;

endmodule

// File: rtl/layer7_window_fetcher.sv
// Walks every KxK window of the layer-6 result map, gathers it, presents it to layer 7.
// Latency: K*K read cycles per window, presented the cycle after the last tap is captured.
// Backpressure: win_ready low holds the window (and stops all reads) indefinitely.
// Ports: clk, rst, start in; busy, done out; win_if (master) carries the memory
// read port and the window valid/ready bus.
module layer7_window_fetcher
  import layer7_fetch_pkg::*;
#(
  parameter int unsigned MAP_W  = MAP_W_DEF,
  parameter int unsigned K      = K_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  layer7_window_fetcher_if.master  win_if
);

  localparam int unsigned BUF_W = K * K * DATA_W;
  localparam int unsigned IDX_W = $clog2(BUF_W);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;

  logic             cnt_clear;
  logic             tap_step;
  logic             win_step;
  logic [CNT_W-1:0] tap_r, tap_c, wr, wc;
  logic             tap_last, win_last;

  logic             rd_vld;
  logic             win_vld;
  logic             done_vld;
  logic [IDX_W-1:0] slot_lsb;

  layer7_win_counter #(
    .MAP_W  (MAP_W),
    .K      (K),
    .STRIDE (STRIDE)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .tap_step (tap_step),
    .win_step (win_step),
    .tap_r    (tap_r),
    .tap_c    (tap_c),
    .wr       (wr),
    .wc       (wc),
    .tap_last (tap_last),
    .win_last (win_last)
  );

  assign slot_lsb = IDX_W'(tap_index(32'(tap_r), 32'(tap_c), K) * DATA_W);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_clear = 1'b0;
    tap_step  = 1'b0;
    win_step  = 1'b0;
    rd_vld    = 1'b0;
    win_vld   = 1'b0;
    done_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // Memory data is combinational, so each cycle reads and captures one tap.
        rd_vld   = 1'b1;
        tap_step = 1'b1;
        buf_d[slot_lsb +: DATA_W] = win_if.layer6_result_output;
        if (tap_last) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        win_vld = 1'b1;
        if (win_if.win_ready) begin
          if (win_last) begin
            state_d = FINISH;
          end else begin
            win_step = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      FINISH: begin
        done_vld = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Addresses are forced to 0 outside FETCH so the memory never sees a stray read.
  assign win_if.read_row_addr             = rd_vld ? 16'(wr + tap_r) : 16'd0;
  assign win_if.read_col_addr             = rd_vld ? 16'(wc + tap_c) : 16'd0;
  assign win_if.layer6_result_read_signal = rd_vld;

  assign win_if.win_valid = win_vld;
  assign win_if.win_data  = buf_q;
  assign win_if.win_row   = 16'(wr);
  assign win_if.win_col   = 16'(wc);

  assign busy = (state_q != IDLE);
  assign done = done_vld;

endmodule

// File: tb/tb_layer7_window_fetcher.sv
// Self-checking bench for layer7_window_fetcher: default map, backpressure, reset abort,
// ignored starts, and two alternate parameter sets (MAP_W=6; STRIDE=2).
// Memory model returns {row[7:0], col[7:0]} for every address.
module tb_layer7_window_fetcher;
  import layer7_fetch_pkg::*;

  localparam int DW = 16;

  typedef struct {
    int          row;
    int          col;
    logic [15:0] tap4;
  } vec_t;

  logic clk;
  logic rst;
  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic rdy0;

  int cyc = 0;
  int t0 = 0;
  int t1 = 0;
  bit mon_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int done_cnt0 = 0;

  int cnt1 = 0, last_r1 = -1, last_c1 = -1, done_rel1 = -1;
  int cnt2 = 0, done_rel2 = -1;
  int seq_r2 [4];
  int seq_c2 [4];
  logic [143:0] data2 [4];
  int range_bad = 0;

  vec_t tbl [9];

  layer7_window_fetcher_if #(.DATA_W(DW), .K(3)) if0 ();
  layer7_window_fetcher_if #(.DATA_W(DW), .K(3)) if1 ();
  layer7_window_fetcher_if #(.DATA_W(DW), .K(3)) if2 ();

  assign if0.layer6_result_output = {if0.read_row_addr[7:0], if0.read_col_addr[7:0]};
  assign if1.layer6_result_output = {if1.read_row_addr[7:0], if1.read_col_addr[7:0]};
  assign if2.layer6_result_output = {if2.read_row_addr[7:0], if2.read_col_addr[7:0]};
  assign if0.win_ready = rdy0;
  assign if1.win_ready = 1'b1;
  assign if2.win_ready = 1'b1;

  layer7_window_fetcher #(.MAP_W(5), .K(3), .STRIDE(1), .DATA_W(DW)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .win_if(if0.master));
  layer7_window_fetcher #(.MAP_W(6), .K(3), .STRIDE(1), .DATA_W(DW)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .win_if(if1.master));
  layer7_window_fetcher #(.MAP_W(5), .K(3), .STRIDE(2), .DATA_W(DW)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .win_if(if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [143:0] build_win(input int r, input int c);
    logic [143:0] w;
    w = '0;
    for (int tr = 0; tr < 3; tr++)
      for (int tc = 0; tc < 3; tc++)
        w[(tr*3+tc)*16 +: 16] = {8'(r + tr), 8'(c + tc)};
    return w;
  endfunction

  // One full pass on u0. stall_win<0 disables backpressure; poke pulses start mid-pass.
  task automatic run_pass(input int stall_win, input int stall_len, input bit poke, input bit mon);
    int n, rel, extra, base, seen;
    logic [143:0] expw;
    base = done_cnt0;
    @(negedge clk);
    start0 = 1'b1;
    t0 = cyc + 1;
    mon_en = mon;
    rdy0 = (stall_win == 0) ? 1'b0 : 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_after_start", busy0, 1'b1);
    chk("rd_first_cycle", if0.layer6_result_read_signal, 1'b1);
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (!if0.win_valid && n < 400) begin
        @(negedge clk);
        n++;
        start0 = (poke && i == 1 && (cyc - t0) == 12) ? 1'b1 : 1'b0;
      end
      start0 = 1'b0;
      if (!if0.win_valid) begin
        chk("valid_timeout", 1'b0, 1'b1);
        mon_en = 1'b0;
        return;
      end
      rel = cyc - t0;
      extra = (stall_win >= 0 && i > stall_win) ? stall_len : 0;
      expw = build_win(tbl[i].row, tbl[i].col);
      chk("valid_cycle", rel, 9 + 10*i + extra);
      chk("win_row", if0.win_row, tbl[i].row);
      chk("win_col", if0.win_col, tbl[i].col);
      chk("win_tap4", if0.win_data[4*16 +: 16], tbl[i].tap4);
      chk("win_data", if0.win_data, expw);
      if (poke && i == 2) start0 = 1'b1;
      if (i == stall_win) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_valid", if0.win_valid, 1'b1);
          chk("stall_data", if0.win_data, expw);
          chk("stall_rowcol", {if0.win_row, if0.win_col}, {16'(tbl[i].row), 16'(tbl[i].col)});
          chk("stall_no_read", if0.layer6_result_read_signal, 1'b0);
        end
        rdy0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0;
      chk("valid_drop", if0.win_valid, 1'b0);
      if (i + 1 == stall_win) rdy0 = 1'b0;
    end
    rel = cyc - t0;
    extra = (stall_win >= 0) ? stall_len : 0;
    chk("done_pulse", done0, 1'b1);
    chk("done_cycle", rel, 90 + extra);
    @(negedge clk);
    chk("done_one_cycle", done0, 1'b0);
    chk("busy_after_done", busy0, 1'b0);
    mon_en = 1'b0;
    seen = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      if (if0.win_valid) seen++;
    end
    chk("no_extra_window", seen, 0);
    chk("single_done", done_cnt0 - base, 1);
    chk("data_kept", if0.win_data, build_win(2, 2));
  endtask

  initial begin
    int n, base;
    tbl[0] = '{0, 0, 16'h0101};
    tbl[1] = '{0, 1, 16'h0102};
    tbl[2] = '{0, 2, 16'h0103};
    tbl[3] = '{1, 0, 16'h0201};
    tbl[4] = '{1, 1, 16'h0202};
    tbl[5] = '{1, 2, 16'h0203};
    tbl[6] = '{2, 0, 16'h0301};
    tbl[7] = '{2, 1, 16'h0302};
    tbl[8] = '{2, 2, 16'h0303};

    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    rdy0 = 1'b1;

    fork
      // u0 address model / range monitor and done counter
      forever begin : mon0
        int rel, w, tp, er, ec;
        bit erd;
        @(negedge clk);
        if (done0) done_cnt0++;
        if (!rst) begin
          chk("addr_hi_bits", {if0.read_row_addr[15:3], if0.read_col_addr[15:3]}, 26'd0);
          if (mon_en) begin
            rel = cyc - t0;
            if (rel >= 0 && rel < 90) begin
              w = rel / 10;
              tp = rel % 10;
              erd = (tp != 9);
              er = erd ? (w / 3 + tp / 3) : 0;
              ec = erd ? (w % 3 + tp % 3) : 0;
              chk("rd_strobe", if0.layer6_result_read_signal, erd);
              chk("rd_row", if0.read_row_addr, er);
              chk("rd_col", if0.read_col_addr, ec);
            end
          end
        end
      end
      // u1/u2 window recorders
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (if0.layer6_result_read_signal && (if0.read_row_addr > 4 || if0.read_col_addr > 4)) range_bad++;
          if (if1.layer6_result_read_signal && (if1.read_row_addr > 5 || if1.read_col_addr > 5)) range_bad++;
          if (if2.layer6_result_read_signal && (if2.read_row_addr > 4 || if2.read_col_addr > 4)) range_bad++;
          if (if1.win_valid) begin
            cnt1++;
            last_r1 = int'(if1.win_row);
            last_c1 = int'(if1.win_col);
          end
          if (if2.win_valid) begin
            if (cnt2 < 4) begin
              seq_r2[cnt2] = int'(if2.win_row);
              seq_c2[cnt2] = int'(if2.win_col);
              data2[cnt2] = if2.win_data;
            end
            cnt2++;
          end
          if (done1) done_rel1 = cyc - t1;
          if (done2) done_rel2 = cyc - t1;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_valid", if0.win_valid, 1'b0);
    chk("rst_rd", if0.layer6_result_read_signal, 1'b0);
    chk("rst_addr", {if0.read_row_addr, if0.read_col_addr}, 32'd0);
    chk("rst_data", if0.win_data, 144'd0);
    chk("rst_rowcol", {if0.win_row, if0.win_col}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_pass(-1, 0, 1'b0, 1'b1);   // nominal pass with full address trace
    run_pass(4, 20, 1'b0, 1'b0);   // 20-cycle stall on window 4
    run_pass(-1, 0, 1'b1, 1'b0);   // start pulsed in FETCH and PRESENT
    run_pass(-1, 0, 1'b0, 1'b0);   // second start after done

    // Reset in the 3rd FETCH cycle of window 4, origin (1,1): tap 2 reads (1,3).
    @(negedge clk);
    start0 = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while ((cyc - t0) != 42 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_rd", if0.layer6_result_read_signal, 1'b1);
    chk("pre_rst_addr", {if0.read_row_addr, if0.read_col_addr}, {16'd1, 16'd3});
    base = done_cnt0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", u0.state_q, IDLE);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_valid", if0.win_valid, 1'b0);
    chk("abort_rd", if0.layer6_result_read_signal, 1'b0);
    chk("abort_addr", {if0.read_row_addr, if0.read_col_addr}, 32'd0);
    chk("abort_data", if0.win_data, 144'd0);
    chk("abort_rowcol", {if0.win_row, if0.win_col}, 32'd0);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort_no_done", done_cnt0 - base, 0);
    chk("abort_idle", busy0, 1'b0);
    run_pass(-1, 0, 1'b0, 1'b1);   // full pass after abort

    // Alternate parameter sets.
    @(negedge clk);
    start1 = 1'b1;
    start2 = 1'b1;
    t1 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    n = 0;
    while ((done_rel1 < 0 || done_rel2 < 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("param_done_seen", (done_rel1 >= 0) && (done_rel2 >= 0), 1'b1);
    chk("m6_windows", cnt1, 16);
    chk("m6_last", {16'(last_r1), 16'(last_c1)}, {16'd3, 16'd3});
    chk("m6_done_cycle", done_rel1, 160);
    chk("s2_windows", cnt2, 4);
    chk("s2_done_cycle", done_rel2, 40);
    for (int i = 0; i < 4; i++) begin
      chk("s2_origin", {16'(seq_r2[i]), 16'(seq_c2[i])},
          {16'((i / 2) * 2), 16'((i % 2) * 2)});
      chk("s2_data", data2[i], build_win((i / 2) * 2, (i % 2) * 2));
    end
    chk("addr_range", range_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
